// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings, widths and helpers for the pipeline register slice
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam int STALL_CNT_W = 32;

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - enable register with synchronous active-low reset, one payload entry
module pipe_data_reg #(
   parameter int              DW          = 32,
   parameter logic [DW-1:0]   RESET_VALUE = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= RESET_VALUE;
      end else if (en) begin
         q <= din;
      end
   end

endmodule

// File: rtl/pipe_reg_slice.sv
// rtl/pipe_reg_slice.sv - valid/ready pipeline register slice with flush and optional skid entry
// Build option PIPE_REG_SLICE_STALL_CNT_EN adds a saturating stall_cnt output.
module pipe_reg_slice
   import pipe_pkg::*;
#(
   parameter int            DW          = 32,
   parameter logic [DW-1:0] RESET_VALUE = '0,
   parameter int            SKID        = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DW-1:0]          din,
   output logic                   out_valid,
   input  logic                   out_ready,
`ifdef PIPE_REG_SLICE_STALL_CNT_EN
   output logic [DW-1:0]          dout,
   output logic [STALL_CNT_W-1:0] stall_cnt
`else
   output logic [DW-1:0]          dout
`endif
);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          accept;
   logic          drain;
   logic          main_en;
   logic [DW-1:0] main_d;

   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;
   assign out_valid = (state != ST_EMPTY);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   pipe_data_reg #(.DW(DW), .RESET_VALUE(RESET_VALUE)) u_main (
      .clk (clk),
      .rst (rst),
      .en  (main_en),
      .din (main_d),
      .q   (dout)
   );

   generate
      if (SKID == 0) begin : g_single
         assign in_ready = !out_valid || out_ready;
         assign main_en  = accept && !flush;
         assign main_d   = din;

         always_comb begin
            state_nxt = state;
            if (flush) begin
               state_nxt = ST_EMPTY;
            end else if (accept) begin
               state_nxt = ST_FULL;
            end else if (drain) begin
               state_nxt = ST_EMPTY;
            end
         end
      end else begin : g_skid
         logic [DW-1:0] skid_q;
         logic          skid_en;

         // Ready comes straight from the state flop, so out_ready never reaches in_ready.
         assign in_ready = (state != ST_FULL);

         pipe_data_reg #(.DW(DW), .RESET_VALUE(RESET_VALUE)) u_skid (
            .clk (clk),
            .rst (rst),
            .en  (skid_en),
            .din (din),
            .q   (skid_q)
         );

         always_comb begin
            state_nxt = state;
            main_en   = 1'b0;
            skid_en   = 1'b0;
            main_d    = din;
            case (state)
               ST_EMPTY: begin
                  if (accept) begin
                     main_en   = 1'b1;
                     state_nxt = ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (accept && drain) begin
                     main_en = 1'b1;
                  end else if (accept) begin
                     skid_en   = 1'b1;
                     state_nxt = ST_FULL;
                  end else if (drain) begin
                     state_nxt = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  if (drain) begin
                     main_en   = 1'b1;
                     main_d    = skid_q;
                     state_nxt = ST_ONE;
                  end
               end
               default: state_nxt = ST_EMPTY;
            endcase
            // Flush drops held and incoming payloads but leaves dout untouched.
            if (flush) begin
               state_nxt = ST_EMPTY;
               main_en   = 1'b0;
               skid_en   = 1'b0;
            end
         end
      end
   endgenerate

`ifdef PIPE_REG_SLICE_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready) begin
         stall_cnt <= sat_inc(stall_cnt);
      end
   end
`endif

endmodule

// File: doc/pipe_reg_slice.md
Name: pipe_reg_slice

Overview:
- Parametrised pipeline register stage with valid/ready handshake, flush and optional skid buffer.
- Replaces bare enable/reset flops between RISC-V pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Provides stall back-pressure and branch/exception flush.
- SKID=1 breaks the combinational ready path at full throughput.

Parameters:
- DW, 32, payload width in bits.
- RESET_VALUE, 0, DW-bit value loaded into dout on reset. The full DW-bit value is used as given, not bit-replicated.
- SKID, 0, 0 = single register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low; sampled on posedge clk.
- flush  input  1  discard all held and incoming data this cycle.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  slice can accept this cycle.
- din  input  DW  upstream payload.
- out_valid  output  1  dout holds a valid payload.
- out_ready  input  1  downstream accepts this cycle.
- dout  output  DW  payload to downstream stage.
- stall_cnt  output  32  only present with PIPE_REG_SLICE_STALL_CNT_EN.

Behaviour:
- Transfer rules: accept = in_valid && in_ready; drain = out_valid && out_ready.
- Priority, highest first: rst==0, then flush, then normal handshake.
- Reset (rst==0 at posedge): out_valid=0; skid entry empty; dout=RESET_VALUE; in_ready=1 from the next cycle; stall_cnt=0.
- Flush: next cycle out_valid=0 and skid empty. Any payload accepted in the flush cycle is dropped. dout keeps its old value (no load, no clear). in_ready=1 next cycle.
- Mid-operation reset: same as reset; pending payloads are lost.
- SKID=0 (states EMPTY, FULL):
  - in_ready = !out_valid || out_ready (combinational).
  - On accept: dout<=din, out_valid<=1. Latency 1 cycle.
  - On drain without accept: out_valid<=0.
  - Accept and drain in the same cycle: dout replaced, out_valid stays 1. Throughput 1 per cycle.
- SKID=1 (states EMPTY, ONE, FULL; in_ready = registered !skid_valid):
  - EMPTY, accept: main<=din -> ONE.
  - ONE, accept and drain: main<=din, stay ONE.
  - ONE, drain only -> EMPTY.
  - ONE, accept, no drain: skid<=din -> FULL; in_ready=0 next cycle.
  - ONE, neither: hold.
  - FULL, drain: main<=skid -> ONE; in_ready=1 next cycle. No accept is possible in FULL.
  - FULL, no drain: hold.
  - No combinational path from out_ready to in_ready.
  - Latency 1 cycle when EMPTY or draining.
- Payload order is strictly FIFO. Data is never duplicated or lost except by flush or reset.
- dout changes only on a load of main. When out_valid=0, dout holds its last value.
- in_valid while in_ready=0: ignored. Upstream must hold din/in_valid (standard rule). The slice does not check this.

Optional Feature:
- Macro: PIPE_REG_SLICE_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset, not by flush.
- Undefined: port and counter logic absent. Handshake behaviour is identical in both builds.

Decomposition:
- Package pipe_pkg:
  - State encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - STALL_CNT_W=32.
- Sub-module pipe_data_reg (DW, RESET_VALUE; clk, rst, en, din, q):
  - Enable register with synchronous active-low reset.
  - Instantiated for the main entry and, when SKID=1, the skid entry.
- Top holds the state/valid logic, generated per SKID.

Test Plan:
- Reset, RESET_VALUE=32'hDEAD_BEEF: hold rst=0 for 2 cycles -> out_valid=0, dout=32'hDEAD_BEEF, in_ready=1 after release.
- SKID=0 streaming: in_valid=1 with din=1..8 each cycle, out_ready=1 -> dout=1..8 on consecutive cycles, one cycle after each accept, no gaps.
- SKID=1 back-pressure: stream din=10,11,12 with out_ready=0 from cycle 2 -> in_ready falls after 11 is accepted. Raise out_ready -> outputs 10,11,12 in order, none lost.
- Flush in FULL (SKID=1) with in_valid=1, din=99 -> next cycle out_valid=0, in_ready=1, 99 never appears; dout unchanged.
- Reset and flush together mid-stream -> reset state; dout=RESET_VALUE.
- With PIPE_REG_SLICE_STALL_CNT_EN: out_valid=1, out_ready=0 for 5 cycles, then a flush -> stall_cnt=5 and unchanged by the flush. Force the counter to the all-ones value -> it stays 32'hFFFF_FFFF.
